wp_decode_seq: RTL and testbench
================================

Name: wp_decode_seq

Overview:
- Sequenced 3-to-8 one-hot decoder; the receive-side counterpart of the team's 8-to-3 priority-free encoder.
- Accepts binary codes over a valid/ready handshake and buffers them in a small FIFO.
- Drives each code as a registered one-hot pattern for a programmable number of cycles, then moves to the next code.
- Used to replay encoded channel indices onto one-hot select/strobe lines.

Parameters:
- CODE_W, 3, input code width; output width is 2**CODE_W.
- HOLD_CYCLES, 4, cycles each one-hot pattern is held; legal range 1..255.
- FIFO_DEPTH, 2, code buffer entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  active-low enable, matching the encoder: 0 = run, 1 = freeze and blank
- din  input  CODE_W  binary code
- din_valid  input  1  din qualifier
- din_ready  output  1  FIFO can accept
- dout  output  2**CODE_W  registered one-hot pattern
- busy  output  1  a code is currently being held (including while frozen)
- done  output  1  one-cycle pulse when a code's hold completes

Behaviour:
- Reset (async, active-high):
  - dout = 0, busy = 0, done = 0, FIFO empty, state = IDLE, hold counter = 0.
  - din_ready = 1 once rst deasserts.
  - Reset mid-hold discards the current code and all buffered codes.
- Handshake:
  - din_ready = !fifo_full, registered-state based; it does not depend on din_valid.
  - A code is accepted on any rising edge with din_valid && din_ready.
  - A push is blocked while full, even if a pop occurs on the same edge.
  - Push and pop on the same edge when not full: both take effect and the occupancy count is unchanged.
- State IDLE:
  - If en = 0 and the FIFO is non-empty: pop, store the code in cur_code, dout <= 1 << code, cnt <= HOLD_CYCLES-1, busy <= 1, go to SHOW.
  - Latency: a code accepted at edge k into an empty FIFO appears on dout at edge k+1.
- State SHOW, with en = 0:
  - cnt != 0: decrement cnt.
  - cnt == 0: done <= 1 for one cycle.
    - If the FIFO is non-empty, pop and load the next code with no gap cycle (dout switches directly from one pattern to the next).
    - Otherwise dout <= 0, busy <= 0, go to IDLE.
- en = 1 (any state):
  - On the next edge dout <= 0. State, cnt and cur_code are frozen, and no pop occurs.
  - FIFO pushes are still accepted.
  - On return to en = 0: dout <= 1 << cur_code on the next edge and the remaining hold count resumes.
  - Total enabled display cycles per code are always exactly HOLD_CYCLES.
- Invariant: dout is always zero or exactly one-hot, never multiple bits set.
- done never asserts while en = 1.
- HOLD_CYCLES = 1: back-to-back codes change dout on every edge.

Optional Feature:
- Macro: WP_DECODE_PARITY_EN.
- Defined:
  - Adds input din_par (1 bit, even parity over din) and output par_err (1 bit).
  - A code whose parity fails is dropped at the FIFO input and never pushed; din_ready behaviour is unchanged.
  - par_err pulses for one cycle on the edge after the bad acceptance; reset value 0.
- Undefined: neither port exists and every accepted code is pushed.

Decomposition:
- Shared package wp_codec_pkg:
  - CODE_W default.
  - State enum {IDLE, SHOW}.
  - Function onehot(code) returning 2**CODE_W bits.
  - Parity function, also used by the encoder side.
- Sub-module wp_code_fifo: parameterised synchronous FIFO with async active-high reset and push/pop/full/empty/count.
- Top level holds the FSM, hold counter, cur_code and output registers.

Test Plan:
- Reset with the FIFO holding 2 codes, asserted mid-hold -> dout = 0, busy = 0, din_ready = 1 immediately, no done pulse.
- en = 0, push din = 3'b101 once, HOLD_CYCLES = 4 -> dout = 8'b00100000 from edge k+1 for exactly 4 cycles, done pulses once, then dout = 0 and busy = 0.
- Push 3, 0 and 7 back-to-back -> din_ready drops after 2 are buffered; dout shows 8'h08, 8'h01, 8'h80 for 4 cycles each with no zero gap; exactly 3 done pulses.
- Freeze during a hold: start code 2, set en = 1 after 2 cycles for 5 cycles, then en = 0 -> dout = 0 during the freeze, then 8'h04 for the remaining 2 cycles; 4 enabled cycles in total.
- Fill the FIFO while en = 1 -> din_ready = 0 when full, dout stays 0; after release the codes are displayed in FIFO order.
- With WP_DECODE_PARITY_EN: push din = 3'b011 with din_par = 1 -> par_err pulses once, dout stays 0, no done pulse.

Source files
------------

// File: rtl/wp_codec_pkg.sv
// Shared codec package: default code width, decoder FSM states and the
// one-hot / parity helpers used by both the encoder and decoder sides.
package wp_codec_pkg;

    localparam int CODE_W_DEFAULT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Wide enough for any code up to 8 bits; callers truncate to their width.
    function automatic logic [255:0] onehot(input logic [7:0] code);
        return 256'(1) << code;
    endfunction

    // Even parity bit: the value that makes the total count of ones even.
    function automatic logic even_par(input logic [7:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/wp_decode_seq_if.sv
// Handshake / display bus of the sequenced one-hot decoder.
// With WP_DECODE_PARITY_EN defined the bus also carries din_par / par_err.
interface wp_decode_seq_if
    import wp_codec_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEFAULT
);
    localparam int DOUT_W = 2**CODE_W;

    logic              en;
    logic [CODE_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [DOUT_W-1:0] dout;
    logic              busy;
    logic              done;
`ifdef WP_DECODE_PARITY_EN
    logic              din_par;
    logic              par_err;

    modport master (output en, din, din_valid, din_par,
                    input  din_ready, dout, busy, done, par_err);
    modport slave  (input  en, din, din_valid, din_par,
                    output din_ready, dout, busy, done, par_err);
`else
    modport master (output en, din, din_valid,
                    input  din_ready, dout, busy, done);
    modport slave  (input  en, din, din_valid,
                    output din_ready, dout, busy, done);
`endif

endinterface

// File: rtl/wp_code_fifo.sv
// Small synchronous FIFO for buffered codes. A push is refused while full,
// even when a pop happens on the same edge.
module wp_code_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push, w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array, no reset needed: occupancy tracking guards reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointers and occupancy count; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wp_decode_seq.sv
// Sequenced 3-to-8 one-hot decoder: buffers codes from a valid/ready
// handshake and shows each as a registered one-hot pattern for HOLD_CYCLES
// enabled cycles. en is active-low (1 freezes and blanks the output).
// Optional feature macro: WP_DECODE_PARITY_EN (din_par check, par_err pulse).
module wp_decode_seq
    import wp_codec_pkg::*;
#(
    parameter int CODE_W      = CODE_W_DEFAULT,
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic           clk,
    input  logic           rst,
    wp_decode_seq_if.slave bus
);
    localparam int DOUT_W = 2**CODE_W;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [CODE_W-1:0] r_cur_code, w_cur_nxt;
    logic [DOUT_W-1:0] r_dout, w_dout_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              w_push, w_pop, w_full, w_empty;
    logic [CODE_W-1:0] w_head;
    logic [DOUT_W-1:0] w_oh_head, w_oh_cur;

`ifdef WP_DECODE_PARITY_EN
    logic w_accept, w_par_bad, r_par_err;

    assign w_accept  = bus.din_valid && !w_full;
    assign w_par_bad = (bus.din_par != even_par(8'(bus.din)));
    assign w_push    = w_accept && !w_par_bad;
    assign bus.par_err = r_par_err;

    // One-cycle flag for a code accepted with bad parity (it is dropped).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_par_err <= 1'b0;
        else     r_par_err <= w_accept && w_par_bad;
    end
`else
    assign w_push = bus.din_valid && !w_full;
`endif

    assign bus.din_ready = !w_full;
    assign bus.dout      = r_dout;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign w_oh_head     = DOUT_W'(onehot(8'(w_head)));
    assign w_oh_cur      = DOUT_W'(onehot(8'(r_cur_code)));

    wp_code_fifo #(.W(CODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bus.din),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State, hold counter, current code and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cur_code <= '0;
            r_dout     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_code <= w_cur_nxt;
            r_dout     <= w_dout_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state logic. While frozen only dout blanks; everything else holds,
    // so the remaining hold count resumes untouched when en drops again.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_cur_code;
        w_dout_nxt  = r_dout;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        if (bus.en) begin
            w_dout_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_dout_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_cur_nxt   = w_head;
                        w_dout_nxt  = w_oh_head;
                        w_cnt_nxt   = 8'(HOLD_CYCLES - 1);
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    w_dout_nxt = w_oh_cur;
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                        if (!w_empty) begin
                            // Back-to-back: switch straight to the next pattern.
                            w_pop      = 1'b1;
                            w_cur_nxt  = w_head;
                            w_dout_nxt = w_oh_head;
                            w_cnt_nxt  = 8'(HOLD_CYCLES - 1);
                        end else begin
                            w_dout_nxt  = '0;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wp_decode_seq.sv
// Directed bench for wp_decode_seq (HOLD_CYCLES=4, FIFO_DEPTH=2).
module tb_wp_decode_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    wp_decode_seq_if #(.CODE_W(3)) bus ();

    wp_decode_seq #(.CODE_W(3), .HOLD_CYCLES(4), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic b, input logic dn);
        chk({tag, ".dout"}, 32'(bus.dout), 32'(d));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".done"}, 32'(bus.done), 32'(dn));
        chk({tag, ".onehot"}, 32'($countones(bus.dout) <= 1), 32'(1));
    endtask

    initial begin
        logic [7:0] exp_d;
        bus.en        = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
`ifdef WP_DECODE_PARITY_EN
        bus.din_par   = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk_out("rst", 8'h00, 1'b0, 1'b0);
        chk("rst.ready", 32'(bus.din_ready), 32'(1));

        // Single code 5, hold 4 cycles then blank
        bus.din = 3'd5; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        chk_out("t1.acc", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t1.hold", 8'h20, 1'b1, 1'b0);
        end
        tick();
        chk_out("t1.end", 8'h00, 1'b0, 1'b1);
        tick();
        chk_out("t1.idle", 8'h00, 1'b0, 1'b0);

        // Back-to-back 3, 0, 7 with no gap
        bus.din = 3'd3; bus.din_valid = 1'b1;
        tick();
        chk("t2.rdy0", 32'(bus.din_ready), 32'(1));
        bus.din = 3'd0;
        tick();
        chk_out("t2.s0", 8'h08, 1'b1, 1'b0);
        chk("t2.rdy1", 32'(bus.din_ready), 32'(1));
        bus.din = 3'd7;
        tick();
        chk_out("t2.s1", 8'h08, 1'b1, 1'b0);
        chk("t2.full", 32'(bus.din_ready), 32'(0));
        bus.din_valid = 1'b0;
        for (int i = 2; i < 12; i++) begin
            tick();
            exp_d = (i < 4) ? 8'h08 : (i < 8) ? 8'h01 : 8'h80;
            chk_out("t2.seq", exp_d, 1'b1, (i == 4 || i == 8));
        end
        tick();
        chk_out("t2.end", 8'h00, 1'b0, 1'b1);
        tick();
        chk_out("t2.idle", 8'h00, 1'b0, 1'b0);

        // Freeze mid-hold on code 2
        bus.din = 3'd2; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        tick();
        chk_out("t3.a", 8'h04, 1'b1, 1'b0);
        tick();
        chk_out("t3.b", 8'h04, 1'b1, 1'b0);
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("t3.frz", 8'h00, 1'b1, 1'b0);
        end
        bus.en = 1'b0;
        tick();
        chk_out("t3.c", 8'h04, 1'b1, 1'b0);
        tick();
        chk_out("t3.d", 8'h04, 1'b1, 1'b0);
        tick();
        chk_out("t3.end", 8'h00, 1'b0, 1'b1);

        // Fill FIFO while frozen; a third push must be refused
        bus.en = 1'b1;
        bus.din = 3'd1; bus.din_valid = 1'b1;
        tick();
        bus.din = 3'd6;
        tick();
        chk("t4.full", 32'(bus.din_ready), 32'(0));
        bus.din = 3'd4;
        tick();
        chk("t4.full2", 32'(bus.din_ready), 32'(0));
        chk_out("t4.frz", 8'h00, 1'b0, 1'b0);
        bus.din_valid = 1'b0;
        bus.en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) chk("t4.rdy", 32'(bus.din_ready), 32'(1));
            exp_d = (i < 4) ? 8'h02 : 8'h40;
            chk_out("t4.seq", exp_d, 1'b1, (i == 4));
        end
        tick();
        chk_out("t4.end", 8'h00, 1'b0, 1'b1);
        tick();
        chk_out("t4.idle", 8'h00, 1'b0, 1'b0);

        // Reset mid-hold with two codes buffered
        bus.din = 3'd1; bus.din_valid = 1'b1;
        tick();
        bus.din = 3'd2;
        tick();
        bus.din = 3'd3;
        tick();
        bus.din_valid = 1'b0;
        chk("t5.full", 32'(bus.din_ready), 32'(0));
        tick();
        chk_out("t5.pre", 8'h02, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("t5.rst", 8'h00, 1'b0, 1'b0);
        chk("t5.rdy", 32'(bus.din_ready), 32'(1));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out("t5.post", 8'h00, 1'b0, 1'b0);
        end

`ifdef WP_DECODE_PARITY_EN
        // Bad parity is dropped; good parity is shown
        bus.din = 3'b011; bus.din_par = 1'b1; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        chk("t6.perr", 32'(bus.par_err), 32'(1));
        chk_out("t6.acc", 8'h00, 1'b0, 1'b0);
        tick();
        chk("t6.perr0", 32'(bus.par_err), 32'(0));
        chk_out("t6.drop", 8'h00, 1'b0, 1'b0);
        bus.din_par = 1'b0; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        chk("t6.ok", 32'(bus.par_err), 32'(0));
        tick();
        chk_out("t6.show", 8'h08, 1'b1, 1'b0);
        repeat (6) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
